// File: rtl/sram_arbiter_nx1.sv
// N-master to 1-slave SRAM-like bus arbiter with in-order response routing.
// Round-robin or fixed priority; an ID FIFO steers each data_ok to its issuer.
module sram_arbiter_nx1 #(
    parameter int N_MST     = 2,
    parameter int MAX_OUTST = 4,
    parameter int PRIO_MODE = 0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [N_MST-1:0]              m_req,
    input  logic [N_MST-1:0]              m_wr,
    input  logic [2*N_MST-1:0]            m_size,
    input  logic [32*N_MST-1:0]           m_addr,
    input  logic [32*N_MST-1:0]           m_wdata,
    output logic [N_MST-1:0]              m_addr_ok,
    output logic [N_MST-1:0]              m_data_ok,
    output logic [32*N_MST-1:0]           m_rdata,
    output logic                          s_req,
    output logic                          s_wr,
    output logic [1:0]                    s_size,
    output logic [31:0]                   s_addr,
    output logic [31:0]                   s_wdata,
    input  logic                          s_addr_ok,
    input  logic                          s_data_ok,
    input  logic [31:0]                   s_rdata,
    output logic [$clog2(MAX_OUTST):0]    outst_cnt,
    output logic                          err_orphan
);

    localparam int IW    = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int PW    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW    = $clog2(MAX_OUTST) + 1;
    localparam int DEPTH = 2 ** PW;
    localparam int RDW   = 32 * N_MST;

    typedef logic [IW-1:0]    id_t;
    typedef logic [PW-1:0]    ptr_t;
    typedef logic [CW-1:0]    cnt_t;
    typedef logic [N_MST-1:0] vec_t;

    logic  lock_vld_q, lock_vld_d;
    id_t   lock_id_q, lock_id_d;
    id_t   rr_ptr_q, rr_ptr_d;
    ptr_t  wr_ptr_q, wr_ptr_d;
    ptr_t  rd_ptr_q, rd_ptr_d;
    cnt_t  cnt_q, cnt_d;
    logic  orphan_q, orphan_d;
    id_t   fifo_q [DEPTH];

    id_t   grant;
    id_t   head;
    logic  found;
    int    idx;
    int    gsel;
    int    hsel;
    logic  req_any;
    logic  fifo_full;
    logic  fifo_empty;
    logic  accept;
    logic  pop;

    assign req_any    = |m_req;
    assign fifo_full  = (cnt_q == cnt_t'(MAX_OUTST));
    assign fifo_empty = (cnt_q == '0);
    assign s_req      = req_any && !fifo_full;
    assign accept     = s_req && s_addr_ok;
    assign pop        = s_data_ok && !fifo_empty;
    assign head       = fifo_q[rd_ptr_q];
    assign gsel       = int'(grant);
    assign hsel       = int'(head);
    assign outst_cnt  = cnt_q;
    assign err_orphan = orphan_q;

    // A held lock pins the grant so the stalled master's payload stays on the bus.
    always_comb begin
        grant = lock_id_q;
        found = 1'b0;
        idx   = 0;
        if (!lock_vld_q) begin
            grant = '0;
            for (int k = 0; k < N_MST; k++) begin
                if (PRIO_MODE != 0) begin
                    idx = k;
                end else begin
                    idx = int'(rr_ptr_q) + k;
                    if (idx >= N_MST) idx = idx - N_MST;
                end
                if (!found && m_req[id_t'(idx)]) begin
                    grant = id_t'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        s_wr    = 1'b0;
        s_size  = '0;
        s_addr  = '0;
        s_wdata = '0;
        if (req_any) begin
            s_wr    = m_wr[grant];
            s_size  = 2'(m_size >> (2 * gsel));
            s_addr  = 32'(m_addr >> (32 * gsel));
            s_wdata = 32'(m_wdata >> (32 * gsel));
        end
    end

    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        m_rdata   = '0;
        if (accept) m_addr_ok = vec_t'(1) << gsel;
        if (pop) begin
            m_data_ok = vec_t'(1) << hsel;
            m_rdata   = RDW'(s_rdata) << (32 * hsel);
        end
    end

    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        rr_ptr_d   = rr_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        orphan_d   = orphan_q;

        if (accept) begin
            lock_vld_d = 1'b0;
        end else if (s_req) begin
            lock_vld_d = 1'b1;
            lock_id_d  = grant;
        end

        if (accept && PRIO_MODE == 0) begin
            if (gsel == N_MST - 1) rr_ptr_d = '0;
            else                   rr_ptr_d = grant + id_t'(1);
        end

        if (accept) wr_ptr_d = wr_ptr_q + ptr_t'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + ptr_t'(1);

        unique case ({accept, pop})
            2'b10:   cnt_d = cnt_q + cnt_t'(1);
            2'b01:   cnt_d = cnt_q - cnt_t'(1);
            default: cnt_d = cnt_q;
        endcase

        if (s_data_ok && fifo_empty) orphan_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
            rr_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            orphan_q   <= 1'b0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            orphan_q   <= orphan_d;
        end
    end

    // Storage needs no reset: the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (resetn && accept) fifo_q[wr_ptr_q] <= grant;
    end

endmodule

// File: tb/tb_sram_arbiter_nx1.sv
// Self-checking bench for sram_arbiter_nx1: one round-robin and one
// fixed-priority instance share stimulus; responses checked via ID queues.
module tb_sram_arbiter_nx1;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  m_req, m_wr;
    logic [3:0]  m_size;
    logic [63:0] m_addr, m_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;

    logic [1:0]  r_m_addr_ok, r_m_data_ok, f_m_addr_ok, f_m_data_ok;
    logic [63:0] r_m_rdata, f_m_rdata;
    logic        r_s_req, r_s_wr, f_s_req, f_s_wr;
    logic [1:0]  r_s_size, f_s_size;
    logic [31:0] r_s_addr, r_s_wdata, f_s_addr, f_s_wdata;
    logic [2:0]  r_outst_cnt, f_outst_cnt;
    logic        r_err_orphan, f_err_orphan;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int fx_q[$];

    always #5 clk = ~clk;

    sram_arbiter_nx1 #(.N_MST(2), .MAX_OUTST(4), .PRIO_MODE(0)) dut (
        .clk(clk), .resetn(resetn),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(r_m_addr_ok), .m_data_ok(r_m_data_ok),
        .m_rdata(r_m_rdata),
        .s_req(r_s_req), .s_wr(r_s_wr), .s_size(r_s_size),
        .s_addr(r_s_addr), .s_wdata(r_s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .s_rdata(s_rdata),
        .outst_cnt(r_outst_cnt), .err_orphan(r_err_orphan)
    );

    sram_arbiter_nx1 #(.N_MST(2), .MAX_OUTST(4), .PRIO_MODE(1)) dut_fx (
        .clk(clk), .resetn(resetn),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(f_m_addr_ok), .m_data_ok(f_m_data_ok),
        .m_rdata(f_m_rdata),
        .s_req(f_s_req), .s_wr(f_s_wr), .s_size(f_s_size),
        .s_addr(f_s_addr), .s_wdata(f_s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .s_rdata(s_rdata),
        .outst_cnt(f_outst_cnt), .err_orphan(f_err_orphan)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic idle_inputs();
        m_req = '0; m_wr = '0; m_size = '0;
        m_addr = '0; m_wdata = '0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        exp_q.delete();
        fx_q.delete();
    endtask

    task automatic set_m(input int i, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        m_req[i] = 1'b1;
        m_wr[i] = wr;
        m_size[2*i +: 2] = sz;
        m_addr[32*i +: 32] = a;
        m_wdata[32*i +: 32] = d;
    endtask

    task automatic clr_m(input int i);
        m_req[i] = 1'b0;
        m_wr[i] = 1'b0;
        m_size[2*i +: 2] = '0;
        m_addr[32*i +: 32] = '0;
        m_wdata[32*i +: 32] = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        tick(); tick();
        mid();
        checks++;
        if (r_s_req !== 1'b0) begin
            failures++; $display("FAIL reset_s_req got=%0h exp=0", r_s_req);
        end
        checks++;
        if (r_m_addr_ok !== 2'b00 || r_m_data_ok !== 2'b00) begin
            failures++;
            $display("FAIL reset_oks got=%b/%b exp=00/00", r_m_addr_ok, r_m_data_ok);
        end
        checks++;
        if (r_m_rdata !== 64'h0 || r_s_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h exp=0", r_m_rdata, r_s_addr);
        end
        checks++;
        if (r_outst_cnt !== 3'd0 || f_outst_cnt !== 3'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0", r_outst_cnt, f_outst_cnt);
        end
        checks++;
        if (r_err_orphan !== 1'b0) begin
            failures++; $display("FAIL reset_orphan got=%0h exp=0", r_err_orphan);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int e;
        set_m(0, 1'b0, 2'd2, 32'h1000, 32'h0);
        s_addr_ok = 1'b1;
        mid();
        checks++;
        if (r_s_req !== 1'b1 || r_s_addr !== 32'h1000) begin
            failures++;
            $display("FAIL single_req got=%0h/%h exp=1/00001000", r_s_req, r_s_addr);
        end
        checks++;
        if (r_m_addr_ok !== 2'b01) begin
            failures++; $display("FAIL single_addr_ok got=%b exp=01", r_m_addr_ok);
        end
        checks++;
        if (r_s_wr !== 1'b0 || r_s_size !== 2'd2) begin
            failures++;
            $display("FAIL single_wr_size got=%0h/%0d exp=0/2", r_s_wr, r_s_size);
        end
        exp_q.push_back(0);
        tick();
        idle_inputs();
        s_data_ok = 1'b1;
        s_rdata = 32'hDEADBEEF;
        mid();
        checks++;
        if (r_outst_cnt !== 3'd1) begin
            failures++; $display("FAIL single_cnt got=%0d exp=1", r_outst_cnt);
        end
        e = exp_q.pop_front();
        checks++;
        if (r_m_data_ok !== 2'(1 << e)) begin
            failures++;
            $display("FAIL single_data_ok got=%b exp=%b", r_m_data_ok, 2'(1 << e));
        end
        checks++;
        if (r_m_rdata[32*e +: 32] !== 32'hDEADBEEF || r_m_rdata[32*(1-e) +: 32] !== 32'h0) begin
            failures++;
            $display("FAIL single_rdata got=%h exp=DEADBEEF in slice %0d", r_m_rdata, e);
        end
        tick();
        idle_inputs();
        mid();
        checks++;
        if (r_outst_cnt !== 3'd0 || r_m_data_ok !== 2'b00) begin
            failures++;
            $display("FAIL single_drain got=%0d/%b exp=0/00", r_outst_cnt, r_m_data_ok);
        end
        tick();
    endtask

    task automatic test_rr();
        int g, e;
        logic [31:0] ea;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_m(0, 1'b0, 2'd2, 32'h2000 + 32'(k * 4), 32'h0);
            set_m(1, 1'b1, 2'd1, 32'h3000 + 32'(k * 4), 32'hC0DE0000 + 32'(k));
            s_addr_ok = 1'b1;
            s_data_ok = (k > 0);
            s_rdata = 32'hA0000000 + 32'(k);
            mid();
            g = k % 2;
            ea = (g == 0) ? 32'h2000 + 32'(k * 4) : 32'h3000 + 32'(k * 4);
            checks++;
            if (r_m_addr_ok !== 2'(1 << g) || r_s_addr !== ea) begin
                failures++;
                $display("FAIL rr_grant k=%0d got=%b/%h exp=%b/%h",
                         k, r_m_addr_ok, r_s_addr, 2'(1 << g), ea);
            end
            checks++;
            if (r_s_wr !== 1'(g) || (g == 1 && r_s_wdata !== 32'hC0DE0000 + 32'(k))) begin
                failures++;
                $display("FAIL rr_payload k=%0d got=%0h/%h exp=%0d", k, r_s_wr, r_s_wdata, g);
            end
            checks++;
            if (r_outst_cnt !== ((k > 0) ? 3'd1 : 3'd0)) begin
                failures++; $display("FAIL rr_cnt k=%0d got=%0d", k, r_outst_cnt);
            end
            if (k > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (r_m_data_ok !== 2'(1 << e) ||
                    r_m_rdata[32*e +: 32] !== 32'hA0000000 + 32'(k)) begin
                    failures++;
                    $display("FAIL rr_resp k=%0d got=%b/%h exp_master=%0d", k, r_m_data_ok, r_m_rdata, e);
                end
            end
            exp_q.push_back(g);
            tick();
        end
        idle_inputs();
        s_data_ok = 1'b1;
        s_rdata = 32'hA0000006;
        mid();
        e = exp_q.pop_front();
        checks++;
        if (r_m_data_ok !== 2'(1 << e) || r_m_rdata[32*e +: 32] !== 32'hA0000006) begin
            failures++;
            $display("FAIL rr_last got=%b/%h exp_master=%0d", r_m_data_ok, r_m_rdata, e);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_fixed();
        int e;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_m(0, 1'b0, 2'd2, 32'h6000 + 32'(k * 4), 32'h0);
            set_m(1, 1'b0, 2'd2, 32'h7000 + 32'(k * 4), 32'h0);
            s_addr_ok = 1'b1;
            mid();
            checks++;
            if (f_m_addr_ok !== 2'b01 || f_s_addr !== 32'h6000 + 32'(k * 4)) begin
                failures++;
                $display("FAIL fixed_grant k=%0d got=%b/%h exp=01", k, f_m_addr_ok, f_s_addr);
            end
            fx_q.push_back(0);
            tick();
        end
        idle_inputs();
        mid();
        checks++;
        if (f_outst_cnt !== 3'd3) begin
            failures++; $display("FAIL fixed_cnt got=%0d exp=3", f_outst_cnt);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            s_data_ok = 1'b1;
            s_rdata = 32'hB0000000 + 32'(k);
            mid();
            e = fx_q.pop_front();
            checks++;
            if (f_m_data_ok !== 2'(1 << e) || f_m_rdata[32*e +: 32] !== 32'hB0000000 + 32'(k)) begin
                failures++;
                $display("FAIL fixed_resp k=%0d got=%b/%h exp_master=%0d", k, f_m_data_ok, f_m_rdata, e);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        int e, ef;
        do_reset();
        set_m(1, 1'b0, 2'd2, 32'h4000, 32'h0);
        mid();
        checks++;
        if (r_s_req !== 1'b1 || r_s_addr !== 32'h4000 || r_m_addr_ok !== 2'b00) begin
            failures++;
            $display("FAIL lock_first got=%0h/%h/%b exp=1/00004000/00", r_s_req, r_s_addr, r_m_addr_ok);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            set_m(0, 1'b0, 2'd2, 32'h5000, 32'h0);
            mid();
            checks++;
            if (r_s_addr !== 32'h4000 || f_s_addr !== 32'h4000) begin
                failures++;
                $display("FAIL lock_hold k=%0d got=%h/%h exp=00004000", k, r_s_addr, f_s_addr);
            end
            checks++;
            if (r_m_addr_ok !== 2'b00 || f_m_addr_ok !== 2'b00) begin
                failures++;
                $display("FAIL lock_no_ok k=%0d got=%b/%b exp=00", k, r_m_addr_ok, f_m_addr_ok);
            end
            tick();
        end
        s_addr_ok = 1'b1;
        mid();
        checks++;
        if (r_m_addr_ok !== 2'b10 || f_m_addr_ok !== 2'b10 || r_s_addr !== 32'h4000) begin
            failures++;
            $display("FAIL lock_accept got=%b/%b/%h exp=10/10/00004000", r_m_addr_ok, f_m_addr_ok, r_s_addr);
        end
        exp_q.push_back(1);
        fx_q.push_back(1);
        tick();
        clr_m(1);
        mid();
        checks++;
        if (r_m_addr_ok !== 2'b01 || r_s_addr !== 32'h5000 || f_s_addr !== 32'h5000) begin
            failures++;
            $display("FAIL lock_release got=%b/%h/%h exp=01/00005000", r_m_addr_ok, r_s_addr, f_s_addr);
        end
        exp_q.push_back(0);
        fx_q.push_back(0);
        tick();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            s_data_ok = 1'b1;
            s_rdata = 32'hC0000000 + 32'(k);
            mid();
            e = exp_q.pop_front();
            ef = fx_q.pop_front();
            checks++;
            if (r_m_data_ok !== 2'(1 << e) || r_m_rdata[32*e +: 32] !== 32'hC0000000 + 32'(k)) begin
                failures++;
                $display("FAIL lock_resp k=%0d got=%b/%h exp_master=%0d", k, r_m_data_ok, r_m_rdata, e);
            end
            checks++;
            if (f_m_data_ok !== 2'(1 << ef)) begin
                failures++;
                $display("FAIL lock_resp_fx k=%0d got=%b exp_master=%0d", k, f_m_data_ok, ef);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_full();
        int e;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_m(0, 1'b1, 2'd2, 32'h8000 + 32'(k * 4), 32'h11110000 + 32'(k));
            s_addr_ok = 1'b1;
            mid();
            checks++;
            if (r_m_addr_ok !== 2'b01) begin
                failures++; $display("FAIL full_fill k=%0d got=%b exp=01", k, r_m_addr_ok);
            end
            exp_q.push_back(0);
            tick();
        end
        set_m(0, 1'b1, 2'd2, 32'h8010, 32'h11110004);
        mid();
        checks++;
        if (r_outst_cnt !== 3'd4 || r_s_req !== 1'b0 || r_m_addr_ok !== 2'b00) begin
            failures++;
            $display("FAIL full_stall got=%0d/%0h/%b exp=4/0/00", r_outst_cnt, r_s_req, r_m_addr_ok);
        end
        tick();
        s_data_ok = 1'b1;
        s_rdata = 32'hD0000000;
        mid();
        checks++;
        if (r_s_req !== 1'b0 || r_m_addr_ok !== 2'b00) begin
            failures++;
            $display("FAIL full_pop_nopush got=%0h/%b exp=0/00", r_s_req, r_m_addr_ok);
        end
        e = exp_q.pop_front();
        checks++;
        if (r_m_data_ok !== 2'(1 << e) || r_m_rdata[32*e +: 32] !== 32'hD0000000) begin
            failures++;
            $display("FAIL full_pop got=%b/%h exp_master=%0d", r_m_data_ok, r_m_rdata, e);
        end
        tick();
        s_data_ok = 1'b0;
        mid();
        checks++;
        if (r_outst_cnt !== 3'd3 || r_s_req !== 1'b1 || r_m_addr_ok !== 2'b01) begin
            failures++;
            $display("FAIL full_refill got=%0d/%0h/%b exp=3/1/01", r_outst_cnt, r_s_req, r_m_addr_ok);
        end
        exp_q.push_back(0);
        tick();
        idle_inputs();
        mid();
        checks++;
        if (r_outst_cnt !== 3'd4) begin
            failures++; $display("FAIL full_cnt4 got=%0d exp=4", r_outst_cnt);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            s_data_ok = 1'b1;
            s_rdata = 32'hD0000001 + 32'(k);
            mid();
            e = exp_q.pop_front();
            checks++;
            if (r_m_data_ok !== 2'(1 << e) || r_m_rdata[32*e +: 32] !== 32'hD0000001 + 32'(k)) begin
                failures++;
                $display("FAIL full_drain k=%0d got=%b/%h exp_master=%0d", k, r_m_data_ok, r_m_rdata, e);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_orphan();
        int e;
        idle_inputs();
        s_data_ok = 1'b1;
        s_rdata = 32'hEEEE0000;
        mid();
        checks++;
        if (r_m_data_ok !== 2'b00 || r_m_rdata !== 64'h0 || r_err_orphan !== 1'b0) begin
            failures++;
            $display("FAIL orphan_resp got=%b/%h/%0h exp=00/0/0", r_m_data_ok, r_m_rdata, r_err_orphan);
        end
        tick();
        idle_inputs();
        mid();
        checks++;
        if (r_err_orphan !== 1'b1 || r_outst_cnt !== 3'd0) begin
            failures++;
            $display("FAIL orphan_set got=%0h/%0d exp=1/0", r_err_orphan, r_outst_cnt);
        end
        tick(); tick(); tick();
        set_m(0, 1'b0, 2'd2, 32'h9000, 32'h0);
        s_addr_ok = 1'b1;
        exp_q.push_back(0);
        tick();
        idle_inputs();
        s_data_ok = 1'b1;
        s_rdata = 32'h12345678;
        mid();
        e = exp_q.pop_front();
        checks++;
        if (r_m_data_ok !== 2'(1 << e) || r_err_orphan !== 1'b1) begin
            failures++;
            $display("FAIL orphan_sticky got=%b/%0h exp_master=%0d err=1", r_m_data_ok, r_err_orphan, e);
        end
        tick();
        idle_inputs();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        mid();
        checks++;
        if (r_err_orphan !== 1'b0 || r_outst_cnt !== 3'd0) begin
            failures++;
            $display("FAIL orphan_clear got=%0h/%0d exp=0/0", r_err_orphan, r_outst_cnt);
        end
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        tick();
        test_reset();
        test_single();
        test_rr();
        test_fixed();
        test_lock();
        test_full();
        test_orphan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
